add_pipe: RTL and testbench
===========================

Name: add_pipe

Overview:
- Parametrised, pipelined successor to the team's combinational 4-bit adder.
- Adds or subtracts two WIDTH-bit operands over STAGES register stages. Each stage resolves one WIDTH/STAGES-bit chunk and passes the carry to the next stage.
- Valid/ready handshake on input and output, so it drops into the datapath between any producer and consumer.
- Result is WIDTH+1 bits, carry included, as the original adder returned a 5-bit sum for 4-bit inputs.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (= latency); 1..WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  a, b, sub are valid this cycle.
- in_ready  output  1  block accepts an operation this cycle.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- sub  input  1  0: a+b, 1: a-b.
- out_valid  output  1  s and ovf hold a result.
- out_ready  input  1  consumer accepts the result this cycle.
- s  output  WIDTH+1  result; s[WIDTH] is the carry out.
- ovf  output  1  signed (two's complement) overflow of the operation.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-low on rst_n: sampled only on the rising edge of clk while rst_n=0.
- Reset values:
  - All stage valid bits = 0, so out_valid = 0.
  - s = 0, ovf = 0.
  - in_ready = 1 in the cycle after reset releases.
- Arithmetic:
  - Let C = WIDTH/STAGES.
  - Subtraction is computed as a + ~b + 1: carry-in to stage 0 = sub, and b is inverted when sub=1.
  - Stage k adds chunk k (bits k*C .. k*C+C-1) plus the carry registered from stage k-1.
  - Upper operand chunks not yet consumed travel with the transaction in skew registers. Already-resolved lower sum chunks travel forward in deskew registers.
  - Result: s[WIDTH-1:0] = low WIDTH bits of the sum. s[WIDTH] = final carry out.
    - Add: s[WIDTH] = 1 means unsigned overflow.
    - Sub: s[WIDTH] = 1 means a >= b unsigned; 0 means a borrow occurred.
  - ovf = carry into MSB XOR carry out of MSB.
- Latency and throughput:
  - An operation accepted in cycle t (in_valid & in_ready) presents out_valid=1 in cycle t+STAGES, provided no stall occurred.
  - One operation per cycle when out_ready is held high.
- Handshake and stall:
  - The pipeline advances as a whole when adv = !out_valid | out_ready.
  - in_ready = adv, combinational.
  - While out_valid=1 and out_ready=0, all stage registers hold, and s, ovf and out_valid stay stable.
  - Bubbles (in_valid=0 when adv=1) propagate as invalid stages; data registers of invalid stages are don't-care, except s and ovf, which hold their last value while out_valid=0.
  - Input accepted and output taken in the same cycle is legal and loses nothing.
- Reset mid-operation:
  - All in-flight transactions are discarded; nothing emerges afterwards.
  - out_valid = 0 in the cycle following the reset edge.
- STAGES=1: purely registered adder with one-cycle latency; same handshake rules.

Optional Feature:
- Macro ADD_PIPE_SAT_EN.
- Defined:
  - Extra input port sat (1 bit) travels with each transaction.
  - When sat=1, the low WIDTH bits of the result saturate unsigned: add with carry out → all ones; sub with borrow (final carry=0) → all zeros.
  - s[WIDTH] and ovf still report the raw, unsaturated carry and overflow.
  - Latency unchanged.
- Not defined:
  - No sat port.
  - Result is always the wrapped (modular) result.

Test Plan:
All scenarios use WIDTH=16, STAGES=4.
1. Reset low 2 cycles, then a=0x0003, b=0x0005, sub=0, out_ready=1 → out_valid rises exactly 4 cycles after acceptance; s=0x00008, ovf=0.
2. a=0xFFFF, b=0x0001, add (full carry ripple through all stages) → s=0x10000, ovf=0. Then a=0x7FFF, b=0x0001 → s=0x08000, ovf=1.
3. sub: a=0x0005, b=0x0008 → s=0x0FFFD (s[16]=0, borrow). Then a=0x8000, b=0x0001 → s=0x17FFF, ovf=1.
4. Stream 8 back-to-back random operations with out_ready=1 → 8 consecutive out_valid cycles, results in order matching a golden a±b model. Then hold out_ready=0 for 5 cycles mid-stream → in_ready=0, s stable, no loss or duplication after release.
5. Assert rst_n=0 for one cycle while 3 operations are in flight → out_valid=0 next cycle; no stale result appears in the following 6 cycles.
6. With ADD_PIPE_SAT_EN defined, sat=1:
   - 0xFFF0+0x0020 → s[15:0]=0xFFFF, s[16]=1.
   - 0x0002−0x0003 → s[15:0]=0x0000, s[16]=0.
   - With sat=0, same operands → wrapped values 0x0010 and 0xFFFF.

Source files
------------

// File: rtl/add_pipe.sv
// add_pipe: pipelined WIDTH-bit add/sub, one WIDTH/STAGES-bit chunk resolved per stage.
// Latency: STAGES cycles from acceptance to out_valid; one op per cycle at full rate.
// Backpressure: the whole pipe advances only when out_valid=0 or out_ready=1; in_ready mirrors that.
// Optional unsigned saturation of the result is enabled with `define ADD_PIPE_SAT_EN.

module add_pipe #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
`ifdef ADD_PIPE_SAT_EN
   input  logic             sat,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   s,
   output logic             ovf
);

   // Chunk width handled by each stage, and the width of a chunk sum with its carry.
   localparam int C   = WIDTH / STAGES;
   localparam int CP1 = C + 1;

   // Pipeline-wide advance: the output slot is free or is being drained this cycle.
   logic adv;

   // Per-stage registers. Operand skew registers are kept right-aligned: each stage
   // shifts the consumed chunk out, so the next stage always works on bits [C-1:0].
   // The sum deskew register fills from the top, so after STAGES shifts every
   // resolved chunk sits in its final position.
   logic [STAGES-1:0] vld_q;
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic              cy_q  [STAGES];
`ifdef ADD_PIPE_SAT_EN
   logic              sub_q [STAGES];
   logic              sat_q [STAGES];
`endif

   // Stage inputs (what each stage sees this cycle) and their next-state values.
   logic [STAGES-1:0] st_vld;
   logic [WIDTH-1:0]  st_a   [STAGES];
   logic [WIDTH-1:0]  st_b   [STAGES];
   logic [WIDTH-1:0]  st_sum [STAGES];
   logic              st_cy  [STAGES];
`ifdef ADD_PIPE_SAT_EN
   logic              st_sub [STAGES];
   logic              st_sat [STAGES];
`endif
   logic [C:0]        cs     [STAGES];
   logic [WIDTH-1:0]  a_d    [STAGES];
   logic [WIDTH-1:0]  b_d    [STAGES];
   logic [WIDTH-1:0]  sum_d  [STAGES];
   logic              cy_d   [STAGES];

   // Output holding registers: only loaded by valid results, so they keep the last
   // result while bubbles pass through.
   logic [WIDTH:0]    s_q;
   logic [WIDTH:0]    s_d;
   logic              ovf_q;
   logic              ovf_d;
   logic [WIDTH-1:0]  res_lo;

   // Handshake: ready whenever the pipe can move.
   always_comb begin
      adv      = !vld_q[STAGES-1] || out_ready;
      in_ready = adv;
   end

   // Stage wiring and per-stage chunk adders; subtraction is a + ~b + 1.
   always_comb begin
      st_vld[0] = in_valid;
      st_a[0]   = a;
      st_b[0]   = sub ? ~b : b;
      st_cy[0]  = sub;
      st_sum[0] = '0;
`ifdef ADD_PIPE_SAT_EN
      st_sub[0] = sub;
      st_sat[0] = sat;
`endif
      for (int k = 1; k < STAGES; k++) begin
         st_vld[k] = vld_q[k-1];
         st_a[k]   = a_q[k-1];
         st_b[k]   = b_q[k-1];
         st_cy[k]  = cy_q[k-1];
         st_sum[k] = sum_q[k-1];
`ifdef ADD_PIPE_SAT_EN
         st_sub[k] = sub_q[k-1];
         st_sat[k] = sat_q[k-1];
`endif
      end
      for (int k = 0; k < STAGES; k++) begin
         cs[k]    = {1'b0, st_a[k][C-1:0]} + {1'b0, st_b[k][C-1:0]} + CP1'(st_cy[k]);
         a_d[k]   = st_a[k] >> C;
         b_d[k]   = st_b[k] >> C;
         sum_d[k] = (st_sum[k] >> C) | (WIDTH'(cs[k][C-1:0]) << (WIDTH - C));
         cy_d[k]  = cs[k][C];
      end
   end

   // Final result: carry out, signed overflow from MSB carries, optional saturation.
   always_comb begin
      // Carry into the MSB is a ^ b' ^ sum at the MSB; overflow is that XOR carry out.
      ovf_d  = st_a[STAGES-1][C-1] ^ st_b[STAGES-1][C-1]
             ^ cs[STAGES-1][C-1] ^ cs[STAGES-1][C];
      res_lo = sum_d[STAGES-1];
`ifdef ADD_PIPE_SAT_EN
      if (st_sat[STAGES-1]) begin
         if (!st_sub[STAGES-1] && cy_d[STAGES-1]) begin
            res_lo = '1;
         end else if (st_sub[STAGES-1] && !cy_d[STAGES-1]) begin
            res_lo = '0;
         end
      end
`endif
      // The carry bit always reports the raw, unsaturated carry.
      s_d = {cy_d[STAGES-1], res_lo};
   end

   // Stage registers: whole pipe moves on adv, holds otherwise; reset drops all work.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= '0;
         s_q   <= '0;
         ovf_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
            cy_q[k]  <= 1'b0;
`ifdef ADD_PIPE_SAT_EN
            sub_q[k] <= 1'b0;
            sat_q[k] <= 1'b0;
`endif
         end
      end else if (adv) begin
         vld_q <= st_vld;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            sum_q[k] <= sum_d[k];
            cy_q[k]  <= cy_d[k];
`ifdef ADD_PIPE_SAT_EN
            sub_q[k] <= st_sub[k];
            sat_q[k] <= st_sat[k];
`endif
         end
         if (st_vld[STAGES-1]) begin
            s_q   <= s_d;
            ovf_q <= ovf_d;
         end
      end
   end

   // Output drive.
   always_comb begin
      out_valid = vld_q[STAGES-1];
      s         = s_q;
      ovf       = ovf_q;
   end

endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: scoreboard bench for add_pipe (WIDTH=16, STAGES=4).
// Expected {ovf, s} values are queued on acceptance and checked in order on output.
// Covers reset, latency, carry/borrow/overflow corners, streaming, stalls, mid-flight reset.

module tb_add_pipe;

   localparam int W = 16;
   localparam int S = 4;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          in_valid  = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a         = '0;
   logic [W-1:0]  b         = '0;
   logic          sub       = 1'b0;
   logic          sat       = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W:0]    s;
   logic          ovf;

   int            n_cmp     = 0;
   int            n_err     = 0;
   logic [W+1:0]  exp_q [$];
   logic [W+1:0]  last_res  = '0;
   int            run       = 0;
   int            max_run   = 0;
   bit            rnd_rdy   = 1'b0;

   always #5 clk = ~clk;

   add_pipe #(.WIDTH(W), .STAGES(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
`ifdef ADD_PIPE_SAT_EN
      .sat       (sat),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .ovf       (ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Golden model: plain arithmetic on the full operands, signed overflow from sign rules.
   function automatic logic [W+1:0] model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                          input logic sb, input logic st);
      logic [W:0]   full;
      logic [W-1:0] lo;
      logic         ov;
      if (sb) begin
         full = {1'b0, aa} - {1'b0, bb} + 17'h10000;
         ov   = (aa[W-1] != bb[W-1]) && (full[W-1] != aa[W-1]);
      end else begin
         full = {1'b0, aa} + {1'b0, bb};
         ov   = (aa[W-1] == bb[W-1]) && (full[W-1] != aa[W-1]);
      end
      lo = full[W-1:0];
      if (st && !sb && full[W])  lo = '1;
      if (st && sb  && !full[W]) lo = '0;
      return {ov, full[W], lo};
   endfunction

   // Offer one operation; push its expected result in the cycle it is accepted.
   // Called and returns at posedge+1.
   task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic sb,
                       input logic st, input logic [W+1:0] e);
      bit done = 1'b0;
      a = aa; b = bb; sub = sb; sat = st; in_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (in_ready && rst_n) begin
            exp_q.push_back(e);
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!done) check("send_timeout", 0, 1);
   endtask

   task automatic send_rnd();
      logic [W-1:0] aa;
      logic [W-1:0] bb;
      logic         sb;
      aa = W'($urandom);
      bb = W'($urandom);
      sb = 1'($urandom_range(0, 1));
      send(aa, bb, sb, 1'b0, model(aa, bb, sb, 1'b0));
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge clk);
      check("drain_left", exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   // Output monitor / scoreboard.
   always @(negedge clk) begin
      logic [W+1:0] e;
      if (rst_n && out_valid && out_ready) begin
         run++;
         if (run > max_run) max_run = run;
         if (exp_q.size() == 0) begin
            check("spurious_out", {14'd0, ovf, s}, 32'hDEAD);
         end else begin
            e = exp_q.pop_front();
            check("result", {14'd0, ovf, s}, {14'd0, e});
            last_res = e;
         end
      end else begin
         run = 0;
      end
   end

   // Random consumer backpressure when enabled.
   initial forever begin
      @(posedge clk); #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1. Reset values, release, first-op latency.
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_s", s, 0);
      check("rst_ovf", ovf, 0);
      rst_n = 1'b1;
      check("in_ready_after_rst", in_ready, 1);
      a = 16'h0003; b = 16'h0005; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      check("accept_first", in_ready, 1);
      exp_q.push_back({1'b0, 17'h00008});
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 1; i <= S; i++) begin
         @(negedge clk);
         check($sformatf("latency_c%0d", i), out_valid, (i == S) ? 1 : 0);
      end
      @(posedge clk); #1;
      drain();

      // 2. Full ripple carry, signed overflow on add.
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 17'h10000});
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 17'h08000});
      drain();
      repeat (3) @(posedge clk);
      #1;
      check("hold_after_bubbles", {14'd0, ovf, s}, {14'd0, last_res});
      check("idle_out_valid", out_valid, 0);

      // 3. Subtraction: borrow, and signed overflow.
      send(16'h0005, 16'h0008, 1'b1, 1'b0, {1'b0, 17'h0FFFD});
      send(16'h8000, 16'h0001, 1'b1, 1'b0, {1'b1, 17'h17FFF});
      drain();

      // 4. Back-to-back stream, then a 5-cycle stall with the pipe full.
      max_run = 0;
      for (int i = 0; i < 8; i++) send_rnd();
      drain();
      check("b2b_run", max_run, 8);
      for (int i = 0; i < 4; i++) send_rnd();
      begin
         logic [W-1:0] aa;
         logic [W-1:0] bb;
         aa = W'($urandom); bb = W'($urandom);
         a = aa; b = bb; sub = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_s_stable", {14'd0, ovf, s}, {14'd0, exp_q[0]});
            @(posedge clk); #1;
         end
         out_ready = 1'b1;
         send(aa, bb, 1'b1, 1'b0, model(aa, bb, 1'b1, 1'b0));
      end
      for (int i = 0; i < 3; i++) send_rnd();
      drain();

      // 5. Reset with three operations in flight.
      for (int i = 0; i < 3; i++) send_rnd();
      rst_n = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("midrst_out_valid", out_valid, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("midrst_no_stale", out_valid, 0);
      end
      @(posedge clk); #1;

      // Random stream under random backpressure.
      rnd_rdy = 1'b1;
      for (int i = 0; i < 20; i++) send_rnd();
      drain();
      rnd_rdy = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;

`ifdef ADD_PIPE_SAT_EN
      // 6. Saturation and its wrapped counterpart.
      send(16'hFFF0, 16'h0020, 1'b0, 1'b1, {1'b0, 1'b1, 16'hFFFF});
      send(16'h0002, 16'h0003, 1'b1, 1'b1, {1'b0, 1'b0, 16'h0000});
      send(16'hFFF0, 16'h0020, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0010});
      send(16'h0002, 16'h0003, 1'b1, 1'b0, {1'b0, 1'b0, 16'hFFFF});
      drain();
`endif

      repeat (5) @(posedge clk);
      check("final_queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
